// File: rtl/phase_period_detector.sv
// Phase/period detector: measures the period of an asynchronous reference
// square wave and the offset of a feedback square wave relative to it, in
// clk cycles, with glitch rejection and loss-of-signal detection.
module phase_period_detector #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [31:0] MIN_PERIOD  = 32'd16,
   parameter logic [31:0] TIMEOUT     = 32'd10_000_000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ref_in,
   input  logic               fb_in,
   output logic signed [15:0] phase_diff,
   output logic [31:0]        period_cnt_reg,
   output logic               meas_valid,
   output logic               locked,
   output logic               timeout,
   output logic               fb_missing
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      TRACK = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] ref_sync_q, ref_sync_d;
   logic [SYNC_STAGES-1:0] fb_sync_q, fb_sync_d;
   logic                   ref_prev_q, ref_prev_d;
   logic                   fb_prev_q, fb_prev_d;

   state_t                 state_q, state_d;
   logic [31:0]            cnt_q, cnt_d;
   logic [31:0]            fb_off_q, fb_off_d;
   logic                   fb_cap_q, fb_cap_d;

   logic signed [15:0]     phase_q, phase_d;
   logic [31:0]            period_q, period_d;
   logic                   meas_valid_q, meas_valid_d;
   logic                   locked_q, locked_d;
   logic                   timeout_q, timeout_d;
   logic                   fb_missing_q, fb_missing_d;

   logic                   ref_edge;
   logic                   fb_edge;
   logic                   ref_acc;

   // Clamp a 33-bit signed phase into the 16-bit output range.
   function automatic logic signed [15:0] sat16(input logic signed [32:0] x);
      if (x > 33'sd32767) begin
         return 16'sh7fff;
      end else if (x < -33'sd32768) begin
         return 16'sh8000;
      end else begin
         return x[15:0];
      end
   endfunction

   // Offsets in the first half of the period are reported as a lag (positive),
   // offsets in the second half as a lead (negative), avoiding any division.
   function automatic logic signed [15:0] phase_calc(input logic [31:0] off,
                                                     input logic [31:0] per);
      logic signed [32:0] diff;
      if ({off, 1'b0} <= {1'b0, per}) begin
         diff = $signed({1'b0, off});
      end else begin
         diff = $signed({1'b0, off}) - $signed({1'b0, per});
      end
      return sat16(diff);
   endfunction

   assign ref_edge = ref_sync_q[SYNC_STAGES-1] & ~ref_prev_q;
   assign fb_edge  = fb_sync_q[SYNC_STAGES-1] & ~fb_prev_q;
   // In IDLE any edge arms the block; otherwise short periods are glitches.
   assign ref_acc  = ref_edge & ((state_q == IDLE) | (cnt_q >= MIN_PERIOD));

   // Next-state logic: synchronizers, edge detectors, counter, FSM and outputs.
   always_comb begin
      ref_sync_d    = ref_sync_q;
      fb_sync_d     = fb_sync_q;
      ref_sync_d[0] = ref_in;
      fb_sync_d[0]  = fb_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
         ref_sync_d[i] = ref_sync_q[i-1];
         fb_sync_d[i]  = fb_sync_q[i-1];
      end
      ref_prev_d   = ref_sync_q[SYNC_STAGES-1];
      fb_prev_d    = fb_sync_q[SYNC_STAGES-1];

      state_d      = state_q;
      cnt_d        = (cnt_q < TIMEOUT) ? cnt_q + 32'd1 : cnt_q;
      fb_off_d     = fb_off_q;
      fb_cap_d     = fb_cap_q;
      phase_d      = phase_q;
      period_d     = period_q;
      meas_valid_d = 1'b0;
      locked_d     = locked_q;
      timeout_d    = timeout_q;
      fb_missing_d = fb_missing_q;

      case (state_q)
         IDLE: begin
            if (ref_edge) begin
               state_d   = ARMED;
               cnt_d     = 32'd1;
               timeout_d = 1'b0;
               fb_cap_d  = 1'b0;
               fb_off_d  = 32'd0;
               locked_d  = 1'b0;
            end
         end
         ARMED, TRACK: begin
            if (cnt_q >= TIMEOUT) begin
               // Loss of signal: drop the lock and clear the measurement.
               state_d      = IDLE;
               timeout_d    = 1'b1;
               locked_d     = 1'b0;
               phase_d      = 16'sd0;
               period_d     = 32'd0;
               fb_missing_d = 1'b0;
               fb_cap_d     = 1'b0;
            end else if (ref_acc) begin
               state_d      = TRACK;
               locked_d     = 1'b1;
               cnt_d        = 32'd1;
               period_d     = cnt_q;
               meas_valid_d = 1'b1;
               if (fb_cap_q) begin
                  phase_d      = phase_calc(fb_off_q, cnt_q);
                  fb_missing_d = 1'b0;
               end else begin
                  fb_missing_d = 1'b1;
               end
               // A coincident fb edge belongs to the period just starting.
               fb_cap_d     = fb_edge;
               fb_off_d     = 32'd0;
            end else if (fb_edge && !fb_cap_q) begin
               fb_cap_d = 1'b1;
               fb_off_d = cnt_q;
            end
         end
         default: begin
            state_d  = IDLE;
            locked_d = 1'b0;
         end
      endcase
   end

   // All state registers, cleared asynchronously while rst is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ref_sync_q   <= '0;
         fb_sync_q    <= '0;
         ref_prev_q   <= 1'b0;
         fb_prev_q    <= 1'b0;
         state_q      <= IDLE;
         cnt_q        <= 32'd0;
         fb_off_q     <= 32'd0;
         fb_cap_q     <= 1'b0;
         phase_q      <= 16'sd0;
         period_q     <= 32'd0;
         meas_valid_q <= 1'b0;
         locked_q     <= 1'b0;
         timeout_q    <= 1'b0;
         fb_missing_q <= 1'b0;
      end else begin
         ref_sync_q   <= ref_sync_d;
         fb_sync_q    <= fb_sync_d;
         ref_prev_q   <= ref_prev_d;
         fb_prev_q    <= fb_prev_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         fb_off_q     <= fb_off_d;
         fb_cap_q     <= fb_cap_d;
         phase_q      <= phase_d;
         period_q     <= period_d;
         meas_valid_q <= meas_valid_d;
         locked_q     <= locked_d;
         timeout_q    <= timeout_d;
         fb_missing_q <= fb_missing_d;
      end
   end

   assign phase_diff     = phase_q;
   assign period_cnt_reg = period_q;
   assign meas_valid     = meas_valid_q;
   assign locked         = locked_q;
   assign timeout        = timeout_q;
   assign fb_missing     = fb_missing_q;

endmodule

// File: tb/tb_phase_period_detector.sv
// Scoreboard bench for phase_period_detector: each driven ref period queues
// the measurement it must produce when the next ref edge closes it.
module tb_phase_period_detector;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               ref_in = 1'b0;
   logic               fb_in = 1'b0;
   logic signed [15:0] phase_diff;
   logic [31:0]        period_cnt_reg;
   logic               meas_valid;
   logic               locked;
   logic               timeout;
   logic               fb_missing;

   typedef struct {
      int period;
      int phase;
      bit missing;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;

   // Directed rows: period, fb delay (-1 = no fb), glitch, expected result.
   int   row_p  [8] = '{1000, 1000, 1000, 1000, 1000, 1000, 1000,  800};
   int   row_d  [8] = '{ 100,  500,  501,  700,    0,  100,   -1,  100};
   bit   row_g  [8] = '{   0,    0,    0,    0,    0,    1,    0,    0};
   int   row_ep [8] = '{1000, 1000, 1000, 1000, 1000, 1000, 1000,  800};
   int   row_eph[8] = '{ 100,  500, -499, -300,    0,  100,  100,  100};
   bit   row_em [8] = '{   0,    0,    0,    0,    0,    0,    1,    0};

   always #5 clk = ~clk;

   phase_period_detector #(
      .SYNC_STAGES(2),
      .MIN_PERIOD (32'd16),
      .TIMEOUT    (32'd5000)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ref_in        (ref_in),
      .fb_in         (fb_in),
      .phase_diff    (phase_diff),
      .period_cnt_reg(period_cnt_reg),
      .meas_valid    (meas_valid),
      .locked        (locked),
      .timeout       (timeout),
      .fb_missing    (fb_missing)
   );

   task automatic chk(input string name, input longint act, input longint req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_phase"}, longint'(phase_diff), 0);
      chk({tag, "_period"}, longint'(period_cnt_reg), 0);
      chk({tag, "_meas_valid"}, longint'(meas_valid), 0);
      chk({tag, "_locked"}, longint'(locked), 0);
      chk({tag, "_timeout"}, longint'(timeout), 0);
      chk({tag, "_fb_missing"}, longint'(fb_missing), 0);
   endtask

   // One ref period of p cycles starting with a rising edge; fb pulses at d.
   task automatic run_period(input int p, input int d, input bit glitch,
                             input bit push, input int ep, input int eph,
                             input bit em);
      exp_t e;
      if (push) begin
         e.period  = ep;
         e.phase   = eph;
         e.missing = em;
         sb.push_back(e);
      end
      for (int c = 0; c < p; c++) begin
         @(negedge clk);
         ref_in = glitch ? ((c < 3) || (c >= 5 && c < 7)) : (c < p / 2);
         fb_in  = (d >= 0) && (c >= d) && (c < d + 4);
      end
   endtask

   // Monitor: every measurement pulse must match the oldest queued entry.
   always @(posedge clk) begin
      #1;
      if (rst && meas_valid) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_meas: got meas_valid=1 period=%0d, expected no measurement",
                     period_cnt_reg);
         end else begin
            mon_e = sb.pop_front();
            chk("meas_period", longint'(period_cnt_reg), longint'(mon_e.period));
            chk("meas_phase", longint'(phase_diff), longint'(mon_e.phase));
            chk("meas_fb_missing", longint'(fb_missing), longint'(mon_e.missing));
            chk("meas_locked", longint'(locked), 1);
         end
      end
   end

   initial begin
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // Lock, half-period split, coincident fb, glitch, missing fb, resume.
      for (int r = 0; r < 8; r++) begin
         run_period(row_p[r], row_d[r], row_g[r], 1'b1, row_ep[r], row_eph[r], row_em[r]);
      end

      // Closing edge for the last row, then ref stops.
      for (int c = 0; c <= 5100; c++) begin
         @(negedge clk);
         ref_in = (c < 3);
         fb_in  = 1'b0;
         if (c == 4900) begin
            chk("pre_timeout_flag", longint'(timeout), 0);
            chk("pre_timeout_locked", longint'(locked), 1);
         end
      end
      chk("timeout_flag", longint'(timeout), 1);
      chk("timeout_locked", longint'(locked), 0);
      chk("timeout_phase", longint'(phase_diff), 0);
      chk("timeout_period", longint'(period_cnt_reg), 0);
      chk("timeout_fb_missing", longint'(fb_missing), 0);

      // Next ref edge re-arms and clears the sticky flag.
      run_period(1000, 100, 1'b0, 1'b1, 1000, 100, 1'b0);
      chk("rearm_timeout_clear", longint'(timeout), 0);
      chk("armed_locked", longint'(locked), 0);

      // Reset in the middle of a tracked period.
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         ref_in = (c < 500);
         fb_in  = (c >= 200) && (c < 204);
      end
      chk("track_locked", longint'(locked), 1);
      #3;
      rst = 1'b0;
      #1;
      check_all_zero("async_reset");
      ref_in = 1'b0;
      fb_in  = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // First edge after release only arms; the second one measures.
      run_period(1000, 50, 1'b0, 1'b1, 1000, 50, 1'b0);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         ref_in = (c < 3);
      end
      chk("scoreboard_drained", longint'(sb.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/phase_period_detector.md
PHASE_PERIOD_DETECTOR -- requirements
Module: phase_period_detector

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on each asynchronous input.
REQ-002 SHALL have parameter MIN_PERIOD, default 32'd16: ref edges closer than this many clk cycles are rejected as glitches.
REQ-003 SHALL have parameter TIMEOUT, default 32'd10_000_000: clk cycles without an accepted ref edge before loss of signal.
REQ-004 SHALL have port clk, input, 1: system clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port ref_in, input, 1: asynchronous reference square wave.
REQ-007 SHALL have port fb_in, input, 1: asynchronous feedback square wave from the locally generated signal.
REQ-008 SHALL have port phase_diff, output, signed 16: fb offset from ref in clk cycles; positive means fb lags ref; feeds the PID stage.
REQ-009 SHALL have port period_cnt_reg, output, 32: last measured ref period in clk cycles.
REQ-010 SHALL have port meas_valid, output, 1: one-cycle pulse when phase_diff and period_cnt_reg update.
REQ-011 SHALL have port locked, output, 1: high in state TRACK.
REQ-012 SHALL have port timeout, output, 1: sticky loss-of-signal flag.
REQ-013 SHALL have port fb_missing, output, 1: high when the last closed period contained no fb edge.

Function
REQ-014 SHALL synchronize ref_in and fb_in through SYNC_STAGES flops, then detect rising edges with one further flop; edge pulse latency is SYNC_STAGES+1 cycles.
REQ-015 SHALL keep a 32-bit cycle counter cnt: set to 1 on the cycle after an accepted ref edge, otherwise incremented, saturating at TIMEOUT.
REQ-016 SHALL accept a ref edge only if cnt >= MIN_PERIOD, or in state IDLE; a rejected edge changes no state, counter or output.
REQ-017 SHALL capture fb_off <= cnt on the first fb edge after an accepted ref edge; later fb edges in the same period are ignored.
REQ-018 SHALL, for an fb edge in the same cycle as an accepted ref edge, record fb_off = 0 for the new period and no fb edge for the closing period.
REQ-019 SHALL implement states IDLE, ARMED, TRACK; reset enters IDLE.
REQ-020 SHALL transition IDLE->ARMED on any ref edge, clearing timeout and fb capture; fb edges in IDLE are ignored.
REQ-021 SHALL transition ARMED->TRACK on the next accepted ref edge; TRACK remains TRACK on accepted ref edges.
REQ-022 SHALL transition ARMED or TRACK->IDLE when cnt reaches TIMEOUT, setting timeout=1 and clearing phase_diff, period_cnt_reg and fb_missing to 0, with no meas_valid pulse.
REQ-023 SHALL, on an accepted ref edge in ARMED or TRACK, register outputs one cycle later: period_cnt_reg=P (cnt at that edge) and meas_valid=1.
REQ-024 SHALL compute phase_diff in the same update: if fb_off was captured and 2*fb_off <= P, phase_diff = +fb_off; if captured and 2*fb_off > P, phase_diff = fb_off - P.
REQ-025 SHALL perform the phase arithmetic in 33-bit signed and saturate it to [-32768, 32767]; no division is used.
REQ-026 SHALL, if no fb edge was captured in the closing period, hold phase_diff, set fb_missing=1 and still pulse meas_valid; a captured period clears fb_missing.

Reset
REQ-027 SHALL, while rst=0, force state IDLE, cnt=0, all synchronizer and edge flops to 0, and all outputs to 0.
REQ-028 SHALL, on reset asserted mid-period, discard the partial measurement; the first ref edge after release only arms the block.

Verification
REQ-029 SHALL verify reset: rst low mid-TRACK -> all outputs 0 immediately and locked=0; after release, the first meas_valid occurs only on the second ref edge.
REQ-030 SHALL verify basic lock: ref period 1000 clk with fb delayed 100 clk -> meas_valid on the second ref edge, period_cnt_reg=1000, phase_diff=+100, locked=1.
REQ-031 SHALL verify the half-period split at P=1000: fb delay 500 -> +500; fb delay 501 -> -499; fb delay 700 -> -300; coincident fb -> 0.
REQ-032 SHALL verify glitch rejection with MIN_PERIOD=16: an extra ref pulse 5 clk after an edge -> ignored, next period_cnt_reg=1000.
REQ-033 SHALL verify fb_missing: fb stopped for one period -> fb_missing=1 with phase_diff held; when fb resumes, fb_missing=0 after the next period.
REQ-034 SHALL verify timeout with TIMEOUT=5000: ref stopped -> 5000 cycles after the last edge timeout=1, locked=0, phase_diff=0, period_cnt_reg=0; the next ref edge clears timeout.
